bkg_subtract_engine: RTL and testbench
======================================

Name: bkg_subtract_engine

Overview:
Parametrised successor to the single-mode background subtractor controller. For each valid background pixel (from the dilation path) it reads the co-located raw pixel from the frame buffer and emits raw minus background. The result passes through a selectable arithmetic mode (wrap, clamp-at-zero, absolute difference) plus a programmable offset. It tracks line and frame position, tags output with start-of-frame / end-of-line / end-of-frame, and counts frames. It sits between the dilation stage and the enhanced-image writer.

Parameters:
DW, 8, pixel data width
LINE_PIX, 752, pixels per line
LINES, 480, lines per frame
AW, 19, frame-buffer address width; must satisfy 2^AW >= LINE_PIX*LINES
FCNT_W, 16, frame counter width

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
cfg_mode  in  2  0=wrap, 1=clamp, 2=absdiff, 3=clamp (reserved)
cfg_offset  in  DW  added to result after mode stage
frame_restart  in  1  sync pulse; realigns counters to pixel 0
bkg_valid  in  1  background pixel strobe
bkg_data  in  DW  background pixel
img_rden  out  1  frame-buffer read enable
img_rdaddr  out  AW  frame-buffer read address
img_rddata  in  DW  read data; valid exactly 1 cycle after img_rden
enh_valid  out  1  output pixel strobe
enh_data  out  DW  enhanced pixel
enh_sof  out  1  with enh_valid: first pixel of frame
enh_eol  out  1  with enh_valid: last pixel of line
enh_eof  out  1  with enh_valid: last pixel of frame
frame_cnt  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

Behaviour:
- Reset: all outputs 0. Address, column and row counters 0. Pipeline valids 0. Captured mode = 0, captured offset = 0.
- img_rden = bkg_valid & ~frame_restart, combinational. img_rdaddr = address counter, combinational.
- Counters advance only on accepted beats (img_rden=1):
  - column increments, wrapping at LINE_PIX-1 to 0; on wrap, row increments.
  - at row LINES-1 and column LINE_PIX-1, address, column and row all return to 0.
  - address = row*LINE_PIX + column, held as an incrementing counter (no multiplier).
- frame_restart: highest priority. Counters go to 0 on the next edge. A coincident bkg_valid beat is dropped: no read, no output. Beats already in the pipeline complete with their original tags. frame_cnt is not incremented.
- Config capture: cfg_mode and cfg_offset are latched on an accepted beat at address 0. That beat and every beat of the frame use the latched values. Mid-frame config changes have no effect until the next frame.
- Pipeline, accepted beat at cycle t:
  - S0 (t edge): register bkg_data, the sof/eol/eof tags and the captured config; valid0 <= 1.
  - S1 (t+1 edge): diff = {0,img_rddata} - {0,bkg_q} as a DW+1-bit signed value; register it.
  - S2 (t+2 edge): mode stage, then offset. enh_valid/enh_data/tags asserted for one cycle per beat, so enh_valid rises 3 cycles after bkg_valid.
- Mode stage:
  - wrap: low DW bits of diff.
  - clamp: 0 if diff<0, else diff.
  - absdiff: |diff|.
- Offset stage:
  - wrap: (m + offset) mod 2^DW.
  - clamp/absdiff: min(m + offset, 2^DW-1), computed in DW+1 bits.
- Fully pipelined: back-to-back bkg_valid gives back-to-back enh_valid. No backpressure; downstream must accept every beat.
- frame_cnt increments on the cycle enh_valid & enh_eof is output.
- An asynchronous reset mid-frame clears everything. The next accepted beat is treated as address 0.

Test Plan (bench params LINE_PIX=4, LINES=3):
- Reset then 12 continuous beats, mode 0, offset 0, img=50, bkg=20 -> 12 outputs of 30, first 3 cycles after first bkg_valid; addresses 0..11 then 0; sof on output 0; eol on outputs 3, 7, 11; eof on 11; frame_cnt=1.
- Modes with img=10, bkg=30, offset 0 -> wrap 236; clamp 0; absdiff 20. Each mode applied from a frame start.
- Offset saturation: clamp mode, img=250, bkg=0, offset=10 -> 255. Wrap mode, same inputs -> 4.
- Mid-frame config change: cfg_mode switched 0->1 at pixel 5 with img<bkg -> frame keeps wrap results; next frame produces 0.
- frame_restart asserted with bkg_valid at pixel 6 -> that beat produces no output and no read; next beat reads address 0 and is tagged sof; frame_cnt unchanged.
- Gapped bkg_valid (1-on/2-off) -> address advances only on beats; each output arrives exactly 3 cycles after its beat. Async reset asserted mid-pipeline -> enh_valid drops to 0 immediately and no stale beat emerges.

Source files
------------

// File: rtl/bkg_subtract_engine.sv
// ---------------------------------------------------------------------------
// bkg_subtract_engine
//
// Purpose:
//   Sits between the dilation stage and the enhanced-image writer. For every
//   background pixel strobed in from the dilation path it reads the raw pixel
//   at the same position from the frame buffer and emits (raw - background).
//   The difference goes through a selectable arithmetic mode (wrap, clamp at
//   zero, absolute difference) and then a programmable offset is added.
//   The engine keeps its own column/row/address position, tags each output
//   with start-of-frame / end-of-line / end-of-frame and counts completed
//   frames.
//
// Ports:
//   s_axi_aclk      clock
//   s_axi_aresetn   asynchronous active-low reset
//   cfg_mode        0=wrap, 1=clamp, 2=absdiff, 3=clamp (reserved)
//   cfg_offset      offset added after the mode stage
//   frame_restart   sync pulse, realigns position counters to pixel 0
//   bkg_valid       background pixel strobe
//   bkg_data        background pixel
//   img_rden        frame-buffer read enable (combinational)
//   img_rdaddr      frame-buffer read address (combinational)
//   img_rddata      frame-buffer read data, valid one cycle after img_rden
//   enh_valid       output pixel strobe, 3 cycles after bkg_valid
//   enh_data        enhanced pixel
//   enh_sof         with enh_valid: first pixel of frame
//   enh_eol         with enh_valid: last pixel of line
//   enh_eof         with enh_valid: last pixel of frame
//   frame_cnt       completed frames, wraps
//
// Pipeline (beat accepted in cycle t):
//   S0 @ edge t   : capture background pixel, position tags, frame config
//   S1 @ edge t+1 : signed difference against the raw pixel read at t
//   S2 @ edge t+2 : mode stage + offset stage, drive the output registers
// ---------------------------------------------------------------------------
module bkg_subtract_engine #(
  parameter int DW       = 8,
  parameter int LINE_PIX = 752,
  parameter int LINES    = 480,
  parameter int AW       = 19,
  parameter int FCNT_W   = 16
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [1:0]        cfg_mode,
  input  logic [DW-1:0]     cfg_offset,
  input  logic              frame_restart,
  input  logic              bkg_valid,
  input  logic [DW-1:0]     bkg_data,
  output logic              img_rden,
  output logic [AW-1:0]     img_rdaddr,
  input  logic [DW-1:0]     img_rddata,
  output logic              enh_valid,
  output logic [DW-1:0]     enh_data,
  output logic              enh_sof,
  output logic              enh_eol,
  output logic              enh_eof,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int CW = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
  localparam int RW = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_PIX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(LINES - 1);

  typedef enum logic [1:0] {
    MODE_WRAP  = 2'd0,
    MODE_CLAMP = 2'd1,
    MODE_ABS   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Position counters
  logic [AW-1:0] addr_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  // Configuration latched at the first pixel of each frame
  mode_e         mode_cap_q;
  logic [DW-1:0] offset_cap_q;

  // Current-beat decode
  logic          accept;
  logic          first_pix;
  logic          col_last;
  logic          frame_last;
  mode_e         beat_mode;
  logic [DW-1:0] beat_offset;

  // Stage 0 registers
  logic          valid0_q;
  logic [DW-1:0] bkg0_q;
  logic          sof0_q;
  logic          eol0_q;
  logic          eof0_q;
  mode_e         mode0_q;
  logic [DW-1:0] offset0_q;

  // Stage 1 registers; diff1_q is a DW+1-bit two's complement value
  logic          valid1_q;
  logic [DW:0]   diff1_q;
  logic          sof1_q;
  logic          eol1_q;
  logic          eof1_q;
  mode_e         mode1_q;
  logic [DW-1:0] offset1_q;

  // Stage 2 combinational results
  logic          diff_neg;
  logic [DW-1:0] mode_val;
  logic [DW:0]   offset_sum;
  logic [DW-1:0] result;

  // A coincident frame_restart drops the beat entirely: no read, no output.
  assign accept     = bkg_valid & ~frame_restart;
  assign img_rden   = accept;
  assign img_rdaddr = addr_q;

  assign first_pix  = (addr_q == '0);
  assign col_last   = (col_q == COL_LAST);
  assign frame_last = col_last & (row_q == ROW_LAST);

  // The first pixel of a frame must already use the new configuration, so it
  // bypasses the capture registers; every later pixel uses the captured copy.
  assign beat_mode   = first_pix ? mode_e'(cfg_mode) : mode_cap_q;
  assign beat_offset = first_pix ? cfg_offset : offset_cap_q;

  // Position tracking. The address is kept as its own incrementing counter
  // alongside column/row so no row*LINE_PIX multiply is needed. A restart
  // outranks any beat; the last pixel of a frame returns everything to 0.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (frame_restart) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (accept) begin
      if (frame_last) begin
        addr_q <= '0;
        col_q  <= '0;
        row_q  <= '0;
      end else if (col_last) begin
        addr_q <= addr_q + AW'(1);
        col_q  <= '0;
        row_q  <= row_q + RW'(1);
      end else begin
        addr_q <= addr_q + AW'(1);
        col_q  <= col_q + CW'(1);
      end
    end
  end

  // Latch mode/offset on the first accepted pixel of a frame so that config
  // writes during a frame only take effect from the next frame onwards.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      mode_cap_q   <= MODE_WRAP;
      offset_cap_q <= '0;
    end else if (accept && first_pix) begin
      mode_cap_q   <= mode_e'(cfg_mode);
      offset_cap_q <= cfg_offset;
    end
  end

  // Stage 0: hold the background pixel and everything the beat needs later,
  // while the frame buffer read for this beat is in flight.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      valid0_q  <= 1'b0;
      bkg0_q    <= '0;
      sof0_q    <= 1'b0;
      eol0_q    <= 1'b0;
      eof0_q    <= 1'b0;
      mode0_q   <= MODE_WRAP;
      offset0_q <= '0;
    end else begin
      valid0_q <= accept;
      if (accept) begin
        bkg0_q    <= bkg_data;
        sof0_q    <= first_pix;
        eol0_q    <= col_last;
        eof0_q    <= frame_last;
        mode0_q   <= beat_mode;
        offset0_q <= beat_offset;
      end
    end
  end

  // Stage 1: raw minus background, both zero-extended, so the top bit of the
  // DW+1-bit result is the sign.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      valid1_q  <= 1'b0;
      diff1_q   <= '0;
      sof1_q    <= 1'b0;
      eol1_q    <= 1'b0;
      eof1_q    <= 1'b0;
      mode1_q   <= MODE_WRAP;
      offset1_q <= '0;
    end else begin
      valid1_q <= valid0_q;
      if (valid0_q) begin
        diff1_q   <= {1'b0, img_rddata} - {1'b0, bkg0_q};
        sof1_q    <= sof0_q;
        eol1_q    <= eol0_q;
        eof1_q    <= eof0_q;
        mode1_q   <= mode0_q;
        offset1_q <= offset0_q;
      end
    end
  end

  // Stage 2 arithmetic. The most negative difference is -(2^DW-1), so its
  // magnitude always fits in DW bits and can be formed from the low bits.
  // Reserved mode 3 behaves as clamp. Wrap mode lets the offset overflow;
  // the other modes saturate using the carry out of a DW+1-bit add.
  always_comb begin
    diff_neg   = diff1_q[DW];
    mode_val   = '0;
    offset_sum = '0;
    result     = '0;
    case (mode1_q)
      MODE_WRAP: mode_val = diff1_q[DW-1:0];
      MODE_ABS:  mode_val = diff_neg ? (DW'(0) - diff1_q[DW-1:0]) : diff1_q[DW-1:0];
      default:   mode_val = diff_neg ? '0 : diff1_q[DW-1:0];
    endcase
    offset_sum = {1'b0, mode_val} + {1'b0, offset1_q};
    if (mode1_q == MODE_WRAP) begin
      result = offset_sum[DW-1:0];
    end else begin
      result = offset_sum[DW] ? '1 : offset_sum[DW-1:0];
    end
  end

  // Output registers. Tags are qualified with the valid so they are only
  // ever seen together with enh_valid. The frame counter steps on the same
  // edge that presents an end-of-frame pixel.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      enh_valid <= 1'b0;
      enh_data  <= '0;
      enh_sof   <= 1'b0;
      enh_eol   <= 1'b0;
      enh_eof   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      enh_valid <= valid1_q;
      enh_sof   <= valid1_q & sof1_q;
      enh_eol   <= valid1_q & eol1_q;
      enh_eof   <= valid1_q & eof1_q;
      if (valid1_q) begin
        enh_data <= result;
      end
      if (valid1_q && eof1_q) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bkg_subtract_engine.sv
// ---------------------------------------------------------------------------
// tb_bkg_subtract_engine
//
// Self-checking bench for bkg_subtract_engine with a small 4x3 frame.
// A frame-buffer model answers reads one cycle after img_rden. Each accepted
// beat is turned into an expected output by a plain-arithmetic reference and
// queued with the step at which it must appear; idle steps expect no output.
// ---------------------------------------------------------------------------
module tb_bkg_subtract_engine;

  localparam int DW       = 8;
  localparam int LINE_PIX = 4;
  localparam int LINES    = 3;
  localparam int AW       = 4;
  localparam int FCNT_W   = 16;
  localparam int NPIX     = LINE_PIX * LINES;
  localparam int MAXV     = (1 << DW) - 1;

  logic              s_axi_aclk = 1'b0;
  logic              s_axi_aresetn = 1'b1;
  logic [1:0]        cfg_mode = 2'd0;
  logic [DW-1:0]     cfg_offset = '0;
  logic              frame_restart = 1'b0;
  logic              bkg_valid = 1'b0;
  logic [DW-1:0]     bkg_data = '0;
  logic              img_rden;
  logic [AW-1:0]     img_rdaddr;
  logic [DW-1:0]     img_rddata = '0;
  logic              enh_valid;
  logic [DW-1:0]     enh_data;
  logic              enh_sof;
  logic              enh_eol;
  logic              enh_eof;
  logic [FCNT_W-1:0] frame_cnt;

  typedef struct {
    int due;
    int data;
    bit sof;
    bit eol;
    bit eof;
  } exp_t;

  exp_t q[$];
  int   fb[16];
  int   checks = 0;
  int   errors = 0;
  int   step = 0;
  int   idx = 0;
  int   mode_cap = 0;
  int   off_cap = 0;
  int   fc_model = 0;

  bkg_subtract_engine #(
    .DW(DW), .LINE_PIX(LINE_PIX), .LINES(LINES), .AW(AW), .FCNT_W(FCNT_W)
  ) dut (
    .s_axi_aclk(s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .cfg_mode(cfg_mode),
    .cfg_offset(cfg_offset),
    .frame_restart(frame_restart),
    .bkg_valid(bkg_valid),
    .bkg_data(bkg_data),
    .img_rden(img_rden),
    .img_rdaddr(img_rdaddr),
    .img_rddata(img_rddata),
    .enh_valid(enh_valid),
    .enh_data(enh_data),
    .enh_sof(enh_sof),
    .enh_eol(enh_eol),
    .enh_eof(enh_eof),
    .frame_cnt(frame_cnt)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  // Frame buffer: registered read, data valid the cycle after img_rden.
  always @(posedge s_axi_aclk) begin
    if (img_rden) img_rddata <= DW'(fb[img_rdaddr]);
  end

  // Expected pixel straight from the arithmetic rules of each mode.
  function automatic int ref_pixel(int img, int bkg, int mode, int off);
    int d, m, s;
    d = img - bkg;
    if (mode == 0) begin
      m = (d + (1 << DW)) % (1 << DW);
      return (m + off) % (1 << DW);
    end
    if (mode == 2) m = (d < 0) ? -d : d;
    else           m = (d < 0) ? 0 : d;
    s = m + off;
    return (s > MAXV) ? MAXV : s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (step %0d)", tag, obs, expv, step);
    end
  endtask

  // One clock step: drive the inputs, check the read side, model the beat,
  // clock it, then check whatever output is due in this step.
  task automatic applyStimulus(input bit v, input int b, input bit r);
    exp_t e;
    bkg_valid     = v;
    bkg_data      = DW'(b);
    frame_restart = r;
    #1;
    checkOutput("img_rden", img_rden, (v && !r));
    if (v && !r) begin
      checkOutput("img_rdaddr", img_rdaddr, idx);
      if (idx == 0) begin
        mode_cap = cfg_mode;
        off_cap  = cfg_offset;
      end
      e.due  = step + 2;
      e.data = ref_pixel(fb[idx], b, mode_cap, off_cap);
      e.sof  = (idx == 0);
      e.eol  = ((idx % LINE_PIX) == LINE_PIX - 1);
      e.eof  = (idx == NPIX - 1);
      q.push_back(e);
      idx = (idx + 1) % NPIX;
    end else if (r) begin
      idx = 0;
    end
    @(posedge s_axi_aclk);
    @(negedge s_axi_aclk);
    bkg_valid     = 1'b0;
    frame_restart = 1'b0;
    if (q.size() > 0 && q[0].due == step) begin
      e = q.pop_front();
      if (e.eof) fc_model++;
      checkOutput("enh_valid", enh_valid, 1);
      checkOutput("enh_data", enh_data, e.data);
      checkOutput("enh_sof", enh_sof, e.sof);
      checkOutput("enh_eol", enh_eol, e.eol);
      checkOutput("enh_eof", enh_eof, e.eof);
    end else begin
      checkOutput("enh_valid_idle", enh_valid, 0);
    end
    checkOutput("frame_cnt", frame_cnt, fc_model % (1 << FCNT_W));
    step++;
  endtask

  // Asynchronous reset placed away from clock edges; outputs must clear at once.
  task automatic doReset();
    #2;
    s_axi_aresetn = 1'b0;
    #1;
    checkOutput("rst_enh_valid", enh_valid, 0);
    checkOutput("rst_enh_data", enh_data, 0);
    checkOutput("rst_enh_sof", enh_sof, 0);
    checkOutput("rst_enh_eol", enh_eol, 0);
    checkOutput("rst_enh_eof", enh_eof, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_img_rdaddr", img_rdaddr, 0);
    q.delete();
    idx = 0; mode_cap = 0; off_cap = 0; fc_model = 0;
    @(negedge s_axi_aclk);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0);
  endtask

  task automatic fillFb(input int lo, input int hi);
    for (int i = 0; i < 16; i++) fb[i] = $urandom_range(hi, lo);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fb[i] = 0;
    @(negedge s_axi_aclk);
    doReset();
    idle(2);

    // Constant frame: 50 - 20 = 30 on all 12 pixels, wrap mode, no offset.
    for (int i = 0; i < 16; i++) fb[i] = 50;
    cfg_mode = 2'd0; cfg_offset = '0;
    for (int i = 0; i < NPIX; i++) applyStimulus(1, 20, 0);
    idle(4);

    // Each mode from a frame start with img 10, bkg 30.
    for (int i = 0; i < 16; i++) fb[i] = 10;
    for (int m = 0; m < 4; m++) begin
      cfg_mode = 2'(m); cfg_offset = '0;
      for (int i = 0; i < NPIX; i++) applyStimulus(1, 30, 0);
    end
    idle(4);

    // Offset saturation (clamp) versus overflow (wrap): 250 + 10.
    for (int i = 0; i < 16; i++) fb[i] = 250;
    cfg_mode = 2'd1; cfg_offset = 8'd10;
    for (int i = 0; i < NPIX; i++) applyStimulus(1, 0, 0);
    cfg_mode = 2'd0;
    for (int i = 0; i < NPIX; i++) applyStimulus(1, 0, 0);
    idle(4);

    // Mid-frame mode change with img < bkg: only the next frame clamps.
    fillFb(0, 100);
    cfg_mode = 2'd0; cfg_offset = '0;
    for (int i = 0; i < NPIX; i++) begin
      if (i == 5) cfg_mode = 2'd1;
      applyStimulus(1, $urandom_range(255, 150), 0);
    end
    for (int i = 0; i < NPIX; i++) applyStimulus(1, $urandom_range(255, 150), 0);
    idle(4);

    // Random frames with random mode/offset, config also poked mid-frame.
    for (int f = 0; f < 3; f++) begin
      fillFb(0, 255);
      for (int i = 0; i < NPIX; i++) begin
        cfg_mode   = 2'($urandom_range(3, 0));
        cfg_offset = DW'($urandom_range(255, 0));
        applyStimulus(1, $urandom_range(255, 0), 0);
      end
    end
    idle(4);

    // frame_restart together with a beat at pixel 6: beat dropped, realign.
    fillFb(0, 255);
    cfg_mode = 2'd2; cfg_offset = DW'($urandom_range(40, 0));
    for (int i = 0; i < 6; i++) applyStimulus(1, $urandom_range(255, 0), 0);
    applyStimulus(1, $urandom_range(255, 0), 1);
    for (int i = 0; i < NPIX; i++) applyStimulus(1, $urandom_range(255, 0), 0);
    idle(4);

    // Gapped beats, one on / two off, running across a frame boundary.
    fillFb(0, 255);
    cfg_mode = 2'd1; cfg_offset = DW'($urandom_range(20, 0));
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, $urandom_range(255, 0), 0);
      idle(2);
    end
    idle(3);

    // Async reset with beats in flight: nothing stale may come out after it.
    for (int i = 0; i < 3; i++) applyStimulus(1, $urandom_range(255, 0), 0);
    checkOutput("pre_reset_valid", enh_valid, 1);
    doReset();
    idle(5);
    cfg_mode = 2'd0; cfg_offset = '0;
    for (int i = 0; i < 5; i++) applyStimulus(1, $urandom_range(255, 0), 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
